// File: rtl/sc_run_controller.sv
// sc_run_controller: generates the per-cycle commit enable for the single-cycle
// CPU. Supports free-run, single-step, fixed-length burst, and a PC breakpoint.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | CPU held; waiting for run switch, step press or burst start
//   RUN   | free-run while the run switch is high, until halt/breakpoint
//   STEP  | commit exactly one instruction, then back to IDLE
//   BURST | commit a loaded number of instructions, then back to IDLE
module sc_run_controller #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             run_sw,
    input  logic             step_btn,
    input  logic             burst_go,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             halt_req,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic [31:0]      pc,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic             bp_hit,
    output logic [31:0]      inst_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_STEP  = 2'b10,
        S_BURST = 2'b11
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0] r_run_sync;
    logic [SYNC_STAGES-1:0] r_step_sync;
    logic                   r_step_prev;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
    logic                   r_armed, w_armed_nxt;
    logic                   r_run_block, w_run_block_nxt;
    logic                   r_bp_hit, w_bp_hit_nxt;
    logic [31:0]            r_inst_cnt;

    logic w_run_s;
    logic w_step_s;
    logic w_step_pulse;
    logic w_bp_match;
    logic w_stop;
    logic w_cpu_en;

    assign w_run_s      = r_run_sync[SYNC_STAGES-1];
    assign w_step_s     = r_step_sync[SYNC_STAGES-1];
    assign w_step_pulse = w_step_s & ~r_step_prev;

    // armed keeps a resumed run from re-stopping on the instruction it stopped at
    assign w_bp_match = bp_en & r_armed & (pc == bp_addr);
    assign w_stop     = halt_req | w_bp_match;

    // Commit enable is purely combinational so a stop suppresses this very cycle
    always_comb begin
        w_cpu_en = 1'b0;
        case (r_state)
            S_RUN:   w_cpu_en = w_run_s & ~w_stop;
            S_STEP:  w_cpu_en = ~halt_req;
            S_BURST: w_cpu_en = ~w_stop;
            default: w_cpu_en = 1'b0;
        endcase
    end

    // Synchronizers for the asynchronous switch and button, plus step edge history
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_run_sync  <= '0;
            r_step_sync <= '0;
            r_step_prev <= 1'b0;
        end else begin
            r_run_sync  <= {r_run_sync[SYNC_STAGES-2:0], run_sw};
            r_step_sync <= {r_step_sync[SYNC_STAGES-2:0], step_btn};
            r_step_prev <= w_step_s;
        end
    end

    // Next-state and side-register updates
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_armed_nxt     = r_armed | w_cpu_en;
        w_run_block_nxt = r_run_block;
        w_bp_hit_nxt    = r_bp_hit;
        case (r_state)
            S_IDLE: begin
                if (halt_req) begin
                    w_state_nxt = S_IDLE;
                end else if (w_run_s && !r_run_block) begin
                    w_state_nxt  = S_RUN;
                    w_armed_nxt  = 1'b0;
                    w_bp_hit_nxt = 1'b0;
                end else if (w_step_pulse) begin
                    w_state_nxt  = S_STEP;
                    w_bp_hit_nxt = 1'b0;
                end else if (burst_go && (burst_len != '0)) begin
                    w_state_nxt  = S_BURST;
                    w_cnt_nxt    = burst_len;
                    w_armed_nxt  = 1'b0;
                    w_bp_hit_nxt = 1'b0;
                end
            end
            S_RUN: begin
                if (w_stop) begin
                    w_state_nxt     = S_IDLE;
                    w_run_block_nxt = 1'b1;
                    w_bp_hit_nxt    = w_bp_match & ~halt_req;
                end else if (!w_run_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_STEP: begin
                w_state_nxt = S_IDLE;
            end
            S_BURST: begin
                if (w_stop) begin
                    w_state_nxt  = S_IDLE;
                    w_cnt_nxt    = '0;
                    w_bp_hit_nxt = w_bp_match & ~halt_req;
                end else if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Lowering the switch is what re-enables free-run after a stop
        if (!w_run_s) begin
            w_run_block_nxt = 1'b0;
        end
    end

    // State register and controller flags
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_armed     <= 1'b0;
            r_run_block <= 1'b0;
            r_bp_hit    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_armed     <= w_armed_nxt;
            r_run_block <= w_run_block_nxt;
            r_bp_hit    <= w_bp_hit_nxt;
        end
    end

    // Committed-instruction counter, wraps naturally at 32 bits
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_inst_cnt <= '0;
        end else if (w_cpu_en) begin
            r_inst_cnt <= r_inst_cnt + 32'd1;
        end
    end

    assign cpu_en     = w_cpu_en;
    assign state      = r_state;
    assign bp_hit     = r_bp_hit;
    assign inst_count = r_inst_cnt;

endmodule

// File: tb/tb_sc_run_controller.sv
// Directed bench for sc_run_controller: step, breakpoint stop/resume, burst,
// halt during burst, and asynchronous reset mid-run.
module tb_sc_run_controller;

    localparam int CNT_W = 16;

    logic             clock;
    logic             resetn;
    logic             run_sw;
    logic             step_btn;
    logic             burst_go;
    logic [CNT_W-1:0] burst_len;
    logic             halt_req;
    logic             bp_en;
    logic [31:0]      bp_addr;
    logic [31:0]      pc;
    logic             cpu_en;
    logic [1:0]       state;
    logic             bp_hit;
    logic [31:0]      inst_count;

    int n_checks = 0;
    int n_errors = 0;

    sc_run_controller #(.SYNC_STAGES(2), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .run_sw     (run_sw),
        .step_btn   (step_btn),
        .burst_go   (burst_go),
        .burst_len  (burst_len),
        .halt_req   (halt_req),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc         (pc),
        .cpu_en     (cpu_en),
        .state      (state),
        .bp_hit     (bp_hit),
        .inst_count (inst_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        run_sw    = 1'b0;
        step_btn  = 1'b0;
        burst_go  = 1'b0;
        burst_len = '0;
        halt_req  = 1'b0;
        bp_en     = 1'b0;
        bp_addr   = '0;
        pc        = '0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic wait_state(input string tag, input logic [1:0] exp, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (state == exp) break;
        end
        chk(tag, {30'd0, state}, {30'd0, exp});
    endtask

    logic [9:0] en_pat;

    initial begin
        do_reset();
        #1;
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
        chk("rst_bp_hit", {31'd0, bp_hit}, 32'd0);
        chk("rst_inst", inst_count, 32'd0);

        // single step: press lands on edge 3, enable during the following cycle
        tick();
        step_btn = 1'b1;
        tick();
        chk("step_e1_en", {31'd0, cpu_en}, 32'd0);
        tick();
        chk("step_e2_en", {31'd0, cpu_en}, 32'd0);
        chk("step_e2_state", {30'd0, state}, 32'd0);
        tick();
        chk("step_e3_en", {31'd0, cpu_en}, 32'd1);
        chk("step_e3_state", {30'd0, state}, 32'd2);
        tick();
        chk("step_e4_en", {31'd0, cpu_en}, 32'd0);
        chk("step_e4_state", {30'd0, state}, 32'd0);
        chk("step_inst", inst_count, 32'd1);
        repeat (3) tick();
        chk("step_once_inst", inst_count, 32'd1);
        step_btn = 1'b0;

        // breakpoint at 0x10 during free run
        do_reset();
        bp_en   = 1'b1;
        bp_addr = 32'h10;
        pc      = 32'h0;
        run_sw  = 1'b1;
        wait_state("bp_enter_run", 2'd1, 10);
        chk("bp_pc0_en", {31'd0, cpu_en}, 32'd1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            pc = 32'(4 * k);
            #1;
            chk("bp_pc_en", {31'd0, cpu_en}, 32'd1);
        end
        tick();
        pc = 32'h10;
        #1;
        chk("bp_pc10_en", {31'd0, cpu_en}, 32'd0);
        tick();
        chk("bp_stop_state", {30'd0, state}, 32'd0);
        chk("bp_stop_hit", {31'd0, bp_hit}, 32'd1);
        chk("bp_stop_inst", inst_count, 32'd4);
        repeat (4) tick();
        chk("bp_block_state", {30'd0, state}, 32'd0);
        chk("bp_block_en", {31'd0, cpu_en}, 32'd0);

        // resume: lower and raise the switch; the instruction at 0x10 executes
        run_sw = 1'b0;
        repeat (4) tick();
        chk("bp_idle_hit_kept", {31'd0, bp_hit}, 32'd1);
        run_sw = 1'b1;
        wait_state("bp_resume_run", 2'd1, 10);
        chk("bp_resume_hit", {31'd0, bp_hit}, 32'd0);
        chk("bp_resume_pc10_en", {31'd0, cpu_en}, 32'd1);
        tick();
        pc = 32'h14;
        #1;
        chk("bp_resume_pc14_en", {31'd0, cpu_en}, 32'd1);
        chk("bp_resume_inst", inst_count, 32'd5);

        // burst of 5
        do_reset();
        burst_len = 16'd5;
        burst_go  = 1'b1;
        #1;
        chk("burst_pre_state", {30'd0, state}, 32'd0);
        tick();
        burst_go = 1'b0;
        #1;
        chk("burst_state", {30'd0, state}, 32'd3);
        en_pat = '0;
        for (int i = 0; i < 10; i++) begin
            en_pat[i] = cpu_en;
            tick();
        end
        chk("burst_pattern", {22'd0, en_pat}, 32'h1F);
        chk("burst_end_state", {30'd0, state}, 32'd0);
        chk("burst_inst", inst_count, 32'd5);

        // zero-length burst ignored
        burst_len = 16'd0;
        burst_go  = 1'b1;
        tick();
        burst_go = 1'b0;
        #1;
        chk("burst0_state", {30'd0, state}, 32'd0);
        chk("burst0_en", {31'd0, cpu_en}, 32'd0);
        tick();
        chk("burst0_inst", inst_count, 32'd5);

        // halt on third burst cycle, then halt wins over run switch in IDLE
        do_reset();
        burst_len = 16'd100;
        burst_go  = 1'b1;
        tick();
        burst_go = 1'b0;
        #1;
        chk("halt_c1_en", {31'd0, cpu_en}, 32'd1);
        tick();
        chk("halt_c2_en", {31'd0, cpu_en}, 32'd1);
        tick();
        halt_req = 1'b1;
        run_sw   = 1'b1;
        #1;
        chk("halt_c3_en", {31'd0, cpu_en}, 32'd0);
        chk("halt_c3_state", {30'd0, state}, 32'd3);
        tick();
        chk("halt_idle_state", {30'd0, state}, 32'd0);
        chk("halt_inst", inst_count, 32'd2);
        chk("halt_bp_hit", {31'd0, bp_hit}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("halt_hold_state", {30'd0, state}, 32'd0);
        end
        halt_req = 1'b0;
        wait_state("halt_release_run", 2'd1, 5);

        // asynchronous reset mid-run after 37 commits
        do_reset();
        run_sw = 1'b1;
        wait_state("ar_enter_run", 2'd1, 10);
        repeat (37) tick();
        chk("ar_inst37", inst_count, 32'd37);
        chk("ar_en_before", {31'd0, cpu_en}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("ar_en", {31'd0, cpu_en}, 32'd0);
        chk("ar_inst", inst_count, 32'd0);
        chk("ar_state", {30'd0, state}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
